rom_streamer: RTL and testbench
===============================

ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 Parameter LENGTH, default 'h16000, number of bytes per download; SHALL be 1 to 2^25.
REQ-002 Parameter INDEX, default 0, 8-bit value driven on IOCTL_INDEX for the whole download.
REQ-003 Parameter GAP, default 2, idle clocks after each write strobe; 0 SHALL be legal.
REQ-004 CLK  in  1  single clock for all logic.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 START  in  1  one-cycle request to begin a download.
REQ-007 ABORT  in  1  terminate the download in progress.
REQ-008 SRC_ADDR  out  25  byte address into the backing memory; the memory has 1-cycle synchronous read.
REQ-009 SRC_DATA  in  8  read data, valid one clock after SRC_ADDR.
REQ-010 IOCTL_DOWNLOAD  out  1  high for the entire transfer.
REQ-011 IOCTL_INDEX  out  8  ROM index.
REQ-012 IOCTL_ADDR  out  25  byte address of the current write.
REQ-013 IOCTL_DOUT  out  8  byte for the current write.
REQ-014 IOCTL_WR  out  1  one-cycle write strobe.
REQ-015 IOCTL_WAIT  in  1  sink stall; holds off the next strobe.
REQ-016 BUSY  out  1  high whenever state is not IDLE.
REQ-017 DONE  out  1  one-cycle pulse on normal completion.

Function
REQ-018 All outputs SHALL be registered, with no combinational path from input to output.
REQ-019 States SHALL be IDLE, FETCH, LATCH, WRITE, GAPW, FINISH; the 25-bit byte counter is CNT.
REQ-020 IDLE with START=1 and ABORT=0: next state FETCH; CNT<=0; IOCTL_DOWNLOAD<=1; BUSY<=1; SRC_ADDR<=0.
REQ-021 FETCH: hold for 1 clock with SRC_ADDR=CNT, then go to LATCH.
REQ-022 LATCH: IOCTL_DOUT<=SRC_DATA; IOCTL_ADDR<=CNT; next state WRITE.
REQ-023 WRITE with IOCTL_WAIT=1 sampled: stay in WRITE with IOCTL_WR=0; wait length is unbounded.
REQ-024 WRITE with IOCTL_WAIT=0 sampled: IOCTL_WR=1 for exactly one clock, then go to GAPW.
REQ-025 IOCTL_ADDR and IOCTL_DOUT SHALL stay stable from LATCH until the next LATCH or reset.
REQ-026 GAPW: wait GAP clocks (a GAP=0 build passes through GAPW in zero extra cycles).
- Then if CNT==LENGTH-1, go to FINISH.
- Otherwise CNT<=CNT+1, SRC_ADDR<=CNT+1, and go to FETCH.
REQ-027 With no wait, the byte period SHALL be 3+GAP clocks.
- The first IOCTL_WR SHALL be high in the 3rd clock after the edge that samples START.
REQ-028 FINISH: IOCTL_DOWNLOAD<=0, DONE=1 for one clock, BUSY<=0, then go to IDLE.
REQ-029 IOCTL_DOWNLOAD SHALL fall only after the last IOCTL_WR has deasserted.
REQ-030 START while BUSY=1 SHALL be ignored.
REQ-031 START and ABORT together in IDLE: ABORT wins and the block stays in IDLE.
REQ-032 ABORT=1 in any non-IDLE state: next clock IDLE, IOCTL_DOWNLOAD=0, IOCTL_WR=0, BUSY=0.
- No DONE pulse.
- A strobe pending in WRITE that same cycle SHALL NOT be issued.
REQ-033 CNT SHALL never wrap: CNT==LENGTH-1 always exits to FINISH.
REQ-034 IOCTL_INDEX SHALL be constant INDEX whenever IOCTL_DOWNLOAD=1.

Reset
REQ-035 RESET=1 SHALL force the following at once, regardless of CLK:
- state IDLE, CNT=0, SRC_ADDR=0, IOCTL_ADDR=0, IOCTL_DOUT=0;
- IOCTL_WR=0, IOCTL_DOWNLOAD=0, BUSY=0, DONE=0.
REQ-036 IOCTL_INDEX SHALL reset to INDEX.
REQ-037 Reset mid-transfer SHALL abandon the transfer; no strobe or DONE is emitted after reset release until a new START.

Verification
REQ-038 LENGTH=4, GAP=2, memory=A0..A3, WAIT=0, START pulse -> 4 IOCTL_WR pulses 5 clocks apart; first at START+3; addr/dout 0/A0, 1/A1, 2/A2, 3/A3; DONE once; DOWNLOAD low after.
REQ-039 Same, WAIT held high 7 clocks while in WRITE for byte 1 -> byte-1 strobe delayed exactly 7 clocks; IOCTL_ADDR=1 and DOUT=A1 stable throughout; all 4 bytes correct.
REQ-040 GAP=0, LENGTH=3 -> strobes 3 clocks apart; DONE in the clock after the final GAPW exit.
REQ-041 ABORT during byte 2 of LENGTH=8 -> no further IOCTL_WR; DOWNLOAD=0 and BUSY=0 next clock; DONE never pulses; a new START restarts at address 0.
REQ-042 START asserted mid-transfer, and START+ABORT together in IDLE -> both ignored; transfer count and addresses unchanged.
REQ-043 RESET asynchronously between clock edges during WRITE -> outputs at reset values immediately; no strobe after release.

Source files
------------

// File: rtl/rom_streamer.sv
// Streams LENGTH bytes from a 1-cycle synchronous-read memory onto an ioctl-style
// download port, one write strobe per byte, honouring sink stalls and an abort.
module rom_streamer #(
    parameter int LENGTH = 'h16000,
    parameter int INDEX  = 0,
    parameter int GAP    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    output logic [24:0] o_src_addr,
    input  logic [7:0]  i_src_data,
    output logic        o_ioctl_download,
    output logic [7:0]  o_ioctl_index,
    output logic [24:0] o_ioctl_addr,
    output logic [7:0]  o_ioctl_dout,
    output logic        o_ioctl_wr,
    input  logic        i_ioctl_wait,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, WRITE, GAPW, FINISH} state_t;

    localparam int              GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [24:0]     CNT_LAST = 25'(LENGTH - 1);

    state_t        r_state, w_state;
    logic [24:0]   r_cnt, w_cnt;
    logic [GW-1:0] r_gap, w_gap;
    logic [24:0]   r_src_addr, w_src_addr;
    logic [24:0]   r_addr, w_addr;
    logic [7:0]    r_dout, w_dout;
    logic          r_wr, w_wr;
    logic          r_download, w_download;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic [7:0]    r_index;
    logic          w_advance;

    // NOTE: every output is a register; this block only computes next values, and
    // each variable gets a default first so no latch is inferred.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_gap      = r_gap;
        w_src_addr = r_src_addr;
        w_addr     = r_addr;
        w_dout     = r_dout;
        w_wr       = 1'b0;
        w_download = r_download;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_advance  = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    w_state    = FETCH;
                    w_cnt      = '0;
                    w_src_addr = '0;
                    w_download = 1'b1;
                    w_busy     = 1'b1;
                end
            end
            FETCH: w_state = LATCH;
            LATCH: begin
                w_dout  = i_src_data;
                w_addr  = r_cnt;
                w_state = WRITE;
            end
            WRITE: begin
                if (!i_ioctl_wait) begin
                    w_wr  = 1'b1;
                    w_gap = '0;
                    if (GAP == 0) w_advance = 1'b1;
                    else          w_state   = GAPW;
                end
            end
            GAPW: begin
                if (r_gap == GAP_LAST) w_advance = 1'b1;
                else                   w_gap     = r_gap + GW'(1);
            end
            FINISH: begin
                w_download = 1'b0;
                w_busy     = 1'b0;
                w_state    = IDLE;
            end
            default: w_state = IDLE;
        endcase

        // End of a byte period: either the last byte is out or fetch the next one.
        if (w_advance) begin
            if (r_cnt == CNT_LAST) begin
                w_state = FINISH;
                w_done  = 1'b1;
            end else begin
                w_cnt      = r_cnt + 25'd1;
                w_src_addr = r_cnt + 25'd1;
                w_state    = FETCH;
            end
        end

        if (i_abort && r_state != IDLE) begin
            w_state    = IDLE;
            w_wr       = 1'b0;
            w_download = 1'b0;
            w_busy     = 1'b0;
            w_done     = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_src_addr <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_wr       <= 1'b0;
            r_download <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_index    <= 8'(INDEX);
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_gap      <= w_gap;
            r_src_addr <= w_src_addr;
            r_addr     <= w_addr;
            r_dout     <= w_dout;
            r_wr       <= w_wr;
            r_download <= w_download;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_index    <= 8'(INDEX);
        end
    end

    assign o_src_addr       = r_src_addr;
    assign o_ioctl_download = r_download;
    assign o_ioctl_index    = r_index;
    assign o_ioctl_addr     = r_addr;
    assign o_ioctl_dout     = r_dout;
    assign o_ioctl_wr       = r_wr;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

endmodule

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer: three instances cover GAP=2/LENGTH=4, GAP=0/LENGTH=3
// and GAP=2/LENGTH=8; a selector routes stimulus to one instance and its outputs back.
module tb_rom_streamer;

    logic clk = 1'b0;
    logic rst;
    logic start_in, abort_in, wait_in;
    int   sel;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    logic        start_x [3];
    logic        abort_x [3];
    logic        wait_x  [3];
    logic [24:0] src_addr_x [3];
    logic [7:0]  src_data_x [3];
    logic        dl_x [3];
    logic [7:0]  index_x [3];
    logic [24:0] addr_x [3];
    logic [7:0]  dout_x [3];
    logic        wr_x [3];
    logic        busy_x [3];
    logic        done_x [3];

    logic [7:0] mem [3][8];

    function automatic logic [7:0] exp_data(input int s, input int i);
        case (s)
            0:       return 8'hA0 + 8'(i);
            1:       return 8'hC0 + 8'(i);
            default: return 8'h10 + 8'(i * 3);
        endcase
    endfunction

    function automatic logic [7:0] exp_index(input int s);
        case (s)
            0:       return 8'h05;
            1:       return 8'h3C;
            default: return 8'hA7;
        endcase
    endfunction

    initial begin
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 8; i++) mem[s][i] = exp_data(s, i);
    end

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            start_x[s] = start_in && (sel == s);
            abort_x[s] = abort_in && (sel == s);
            wait_x[s]  = wait_in  && (sel == s);
        end
    end

    always @(posedge clk) begin
        for (int s = 0; s < 3; s++) src_data_x[s] <= mem[s][src_addr_x[s][2:0]];
    end

    rom_streamer #(.LENGTH(4), .INDEX('h05), .GAP(2)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_x[0]), .i_abort(abort_x[0]),
        .o_src_addr(src_addr_x[0]), .i_src_data(src_data_x[0]),
        .o_ioctl_download(dl_x[0]), .o_ioctl_index(index_x[0]),
        .o_ioctl_addr(addr_x[0]), .o_ioctl_dout(dout_x[0]), .o_ioctl_wr(wr_x[0]),
        .i_ioctl_wait(wait_x[0]), .o_busy(busy_x[0]), .o_done(done_x[0]));

    rom_streamer #(.LENGTH(3), .INDEX('h3C), .GAP(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_x[1]), .i_abort(abort_x[1]),
        .o_src_addr(src_addr_x[1]), .i_src_data(src_data_x[1]),
        .o_ioctl_download(dl_x[1]), .o_ioctl_index(index_x[1]),
        .o_ioctl_addr(addr_x[1]), .o_ioctl_dout(dout_x[1]), .o_ioctl_wr(wr_x[1]),
        .i_ioctl_wait(wait_x[1]), .o_busy(busy_x[1]), .o_done(done_x[1]));

    rom_streamer #(.LENGTH(8), .INDEX('hA7), .GAP(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start_x[2]), .i_abort(abort_x[2]),
        .o_src_addr(src_addr_x[2]), .i_src_data(src_data_x[2]),
        .o_ioctl_download(dl_x[2]), .o_ioctl_index(index_x[2]),
        .o_ioctl_addr(addr_x[2]), .o_ioctl_dout(dout_x[2]), .o_ioctl_wr(wr_x[2]),
        .i_ioctl_wait(wait_x[2]), .o_busy(busy_x[2]), .o_done(done_x[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle (counted in edges after the START-sampling edge) at which byte i strobes.
    function automatic int wr_cycle(input int i, input int p, input int wait_len);
        return 3 + i * p + ((i >= 1) ? wait_len : 0);
    endfunction

    task automatic check_reset_values(input int s, input string name);
        n_checks++;
        if (wr_x[s] !== 1'b0 || dl_x[s] !== 1'b0 || busy_x[s] !== 1'b0 || done_x[s] !== 1'b0 ||
            addr_x[s] !== 25'd0 || dout_x[s] !== 8'd0 || src_addr_x[s] !== 25'd0 ||
            index_x[s] !== exp_index(s)) begin
            n_errors++;
            $display("FAIL %s inst%0d: wr=%b dl=%b busy=%b done=%b addr=%h dout=%h src=%h idx=%h, want all zero idx=%h",
                     name, s, wr_x[s], dl_x[s], busy_x[s], done_x[s], addr_x[s], dout_x[s],
                     src_addr_x[s], index_x[s], exp_index(s));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_in = 1'b0; abort_in = 1'b0; wait_in = 1'b0; sel = 0;
        #1;
        for (int s = 0; s < 3; s++) check_reset_values(s, "reset_state");
        #6;
        rst = 1'b0;
    endtask

    // Runs one download on instance s; abort_k / mid_start_k < 0 disable those events.
    task automatic run_xfer(input int s, input int n_bytes, input int gap, input int wait_len,
                            input int mid_start_k, input int abort_k, input string name);
        int p, kw, n_exp, exp_done, last_high, limit, cnt_wr, cnt_done;
        p = 3 + gap;
        kw = 2 + p;
        cnt_wr = 0;
        cnt_done = 0;
        n_exp = 0;
        for (int i = 0; i < n_bytes; i++)
            if (abort_k < 0 || wr_cycle(i, p, wait_len) <= abort_k) n_exp++;
        if (abort_k < 0) begin
            exp_done  = wr_cycle(n_bytes - 1, p, wait_len) + gap;
            last_high = exp_done;
            limit     = exp_done + 4;
        end else begin
            exp_done  = -1;
            last_high = abort_k;
            limit     = abort_k + 10;
        end

        sel = s;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;

        for (int k = 0; k <= limit; k++) begin
            if (k > 0) tick();
            n_checks++;
            if (dl_x[s] !== (k <= last_high) || busy_x[s] !== (k <= last_high)) begin
                n_errors++;
                $display("FAIL %s download/busy k=%0d: dl=%b busy=%b, want %b",
                         name, k, dl_x[s], busy_x[s], (k <= last_high));
            end
            if (k == 0) begin
                n_checks++;
                if (index_x[s] !== exp_index(s)) begin
                    n_errors++;
                    $display("FAIL %s index: got %h, want %h", name, index_x[s], exp_index(s));
                end
            end
            if (wr_x[s] === 1'b1) begin
                n_checks++;
                if (cnt_wr >= n_exp || k != wr_cycle(cnt_wr, p, wait_len)) begin
                    n_errors++;
                    $display("FAIL %s strobe %0d timing: seen at k=%0d, want k=%0d (of %0d)",
                             name, cnt_wr, k, wr_cycle(cnt_wr, p, wait_len), n_exp);
                end else if (addr_x[s] !== 25'(cnt_wr) || dout_x[s] !== exp_data(s, cnt_wr)) begin
                    n_errors++;
                    $display("FAIL %s strobe %0d data: addr=%h dout=%h, want addr=%h dout=%h",
                             name, cnt_wr, addr_x[s], dout_x[s], cnt_wr, exp_data(s, cnt_wr));
                end
                cnt_wr++;
            end
            if (wait_len > 0 && k >= kw && k <= kw + wait_len) begin
                n_checks++;
                if (wr_x[s] !== 1'b0 || addr_x[s] !== 25'd1 || dout_x[s] !== exp_data(s, 1)) begin
                    n_errors++;
                    $display("FAIL %s stall k=%0d: wr=%b addr=%h dout=%h, want wr=0 addr=1 dout=%h",
                             name, k, wr_x[s], addr_x[s], dout_x[s], exp_data(s, 1));
                end
            end
            if (done_x[s] === 1'b1) begin
                cnt_done++;
                n_checks++;
                if (k != exp_done) begin
                    n_errors++;
                    $display("FAIL %s done timing: seen at k=%0d, want k=%0d", name, k, exp_done);
                end
            end
            wait_in  = (wait_len > 0 && k >= kw && k < kw + wait_len);
            start_in = (k == mid_start_k);
            abort_in = (k == abort_k);
        end
        start_in = 1'b0;
        abort_in = 1'b0;
        wait_in  = 1'b0;

        n_checks++;
        if (cnt_wr != n_exp) begin
            n_errors++;
            $display("FAIL %s strobe count: got %0d, want %0d", name, cnt_wr, n_exp);
        end
        n_checks++;
        if (cnt_done != ((abort_k < 0) ? 1 : 0)) begin
            n_errors++;
            $display("FAIL %s done count: got %0d, want %0d", name, cnt_done, (abort_k < 0) ? 1 : 0);
        end
    endtask

    task automatic test_basic();
        run_xfer(0, 4, 2, 0, -1, -1, "basic_len4_gap2");
    endtask

    task automatic test_wait_and_mid_start();
        run_xfer(0, 4, 2, 7, 10, -1, "wait7_midstart");
    endtask

    task automatic test_gap0();
        run_xfer(1, 3, 0, 0, -1, -1, "gap0_len3");
    endtask

    task automatic test_abort_restart();
        run_xfer(2, 8, 2, 0, -1, 12, "abort_byte2");
        run_xfer(2, 8, 2, 0, -1, -1, "restart_after_abort");
    endtask

    task automatic test_start_abort_idle();
        sel = 0;
        start_in = 1'b1;
        abort_in = 1'b1;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (busy_x[0] !== 1'b0 || dl_x[0] !== 1'b0 || wr_x[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL start_abort_idle k=%0d: busy=%b dl=%b wr=%b, want 0 0 0",
                         k, busy_x[0], dl_x[0], wr_x[0]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset_in_write();
        sel = 0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        repeat (7) tick();
        n_checks++;
        if (addr_x[0] !== 25'd1 || dout_x[0] !== exp_data(0, 1)) begin
            n_errors++;
            $display("FAIL pre_reset_write: addr=%h dout=%h, want addr=1 dout=%h",
                     addr_x[0], dout_x[0], exp_data(0, 1));
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_values(0, "async_reset_mid_write");
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (wr_x[0] !== 1'b0 || done_x[0] !== 1'b0 || busy_x[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL post_reset_quiet k=%0d: wr=%b done=%b busy=%b, want 0 0 0",
                         k, wr_x[0], done_x[0], busy_x[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_basic();
        test_wait_and_mid_start();
        test_gap0();
        test_abort_restart();
        test_start_abort_idle();
        test_async_reset_in_write();
        run_xfer(0, 4, 2, 0, -1, -1, "basic_after_reset");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
